// File: rtl/reg_file_4.sv
// Four-entry, 32-bit register file: one synchronous write port, two combinational read ports.
// Optional write-through forwarding when REG_FILE_BYPASS_EN is defined.

module decoder2_4 (
    input  logic       en,
    input  logic [1:0] sel,
    output logic [3:0] onehot
);
    always_comb begin
        onehot = 4'b0000;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end
endmodule

module reg_32bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);
    // The decoded select acts as a load enable; the clock itself is never gated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 32'h0000_0000;
        end else if (load) begin
            q <= d;
        end
    end
endmodule

module mux4_1 (
    input  logic [1:0]  sel,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] in3,
    output logic [31:0] out
);
    always_comb begin
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end
endmodule

module reg_file_4 (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        RegWrite,
    input  logic [1:0]  WriteRegNo,
    input  logic [31:0] WriteData,
    input  logic [1:0]  ReadReg1,
    input  logic [1:0]  ReadReg2,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2
);
    logic [3:0]  write_sel;
    logic [31:0] regs [4];
    logic [31:0] stored1;
    logic [31:0] stored2;

    decoder2_4 u_dec (
        .en     (RegWrite),
        .sel    (WriteRegNo),
        .onehot (write_sel)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_regs
            reg_32bit u_reg (
                .clk   (Clock),
                .rst_n (Reset),
                .load  (write_sel[gi]),
                .d     (WriteData),
                .q     (regs[gi])
            );
        end
    endgenerate

    mux4_1 u_mux1 (
        .sel (ReadReg1),
        .in0 (regs[0]),
        .in1 (regs[1]),
        .in2 (regs[2]),
        .in3 (regs[3]),
        .out (stored1)
    );

    mux4_1 u_mux2 (
        .sel (ReadReg2),
        .in0 (regs[0]),
        .in1 (regs[1]),
        .in2 (regs[2]),
        .in3 (regs[3]),
        .out (stored2)
    );

`ifdef REG_FILE_BYPASS_EN
    // Forward the in-flight write so a same-cycle reader sees it before the edge.
    assign ReadData1 = (RegWrite && Reset && (ReadReg1 == WriteRegNo)) ? WriteData : stored1;
    assign ReadData2 = (RegWrite && Reset && (ReadReg2 == WriteRegNo)) ? WriteData : stored2;
`else
    assign ReadData1 = stored1;
    assign ReadData2 = stored2;
`endif
endmodule

// File: tb/tb_reg_file_4.sv
// Self-checking bench for reg_file_4: directed test-plan steps followed by randomized
// traffic checked against an array model of the four registers.
`timescale 1ns/1ps

module tb_reg_file_4;
    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        RegWrite = 1'b0;
    logic [1:0]  WriteRegNo = 2'd0;
    logic [31:0] WriteData = 32'h0;
    logic [1:0]  ReadReg1 = 2'd0;
    logic [1:0]  ReadReg2 = 2'd1;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model [4] = '{default: 32'h0};

    always #10 Clock = ~Clock;

    reg_file_4 dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .RegWrite   (RegWrite),
        .WriteRegNo (WriteRegNo),
        .WriteData  (WriteData),
        .ReadReg1   (ReadReg1),
        .ReadReg2   (ReadReg2),
        .ReadData1  (ReadData1),
        .ReadData2  (ReadData2)
    );

    function automatic logic [31:0] exp_read(input logic [1:0] idx);
`ifdef REG_FILE_BYPASS_EN
        if (RegWrite && Reset && idx == WriteRegNo) return WriteData;
`endif
        return model[idx];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
        $display("[TB] %s rr1=%0d rr2=%0d observed=%h expected=%h", tag, ReadReg1, ReadReg2, obs, expv);
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_p1"}, ReadData1, exp_read(ReadReg1));
        check({tag, "_p2"}, ReadData2, exp_read(ReadReg2));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
    endtask

    // Drive a write at the falling edge, let it capture, update the model, sample after.
    task automatic do_write(input logic we, input logic [1:0] idx, input logic [31:0] data);
        @(negedge Clock);
        RegWrite = we; WriteRegNo = idx; WriteData = data;
        @(posedge Clock);
        if (we && Reset) model[idx] = data;
        #1;
    endtask

    initial begin
        // Reset held: every index reads zero
        #3;
        check_ports("reset_r0r1");
        for (int i = 0; i < 4; i++) begin
            ReadReg1 = 2'(i); ReadReg2 = 2'(3 - i); #1;
            check_ports("reset_sweep");
        end
        @(negedge Clock);
        Reset = 1'b1;

        // Sequential writes
        do_write(1'b1, 2'd0, 32'hF0F0F0F0);
        do_write(1'b1, 2'd1, 32'hF8F8F8F8);
        do_write(1'b1, 2'd2, 32'hFAFAFAFA);
        do_write(1'b1, 2'd3, 32'hFFFFFFFF);
        ReadReg1 = 2'd0; ReadReg2 = 2'd1; #1;
        check_ports("seq_r0r1");
        ReadReg1 = 2'd2; ReadReg2 = 2'd3; #1;
        check_ports("seq_r2r3");

        // Write disable holds R1
        for (int i = 0; i < 3; i++) do_write(1'b0, 2'd1, 32'h12345678);
        ReadReg1 = 2'd1; #1;
        check("wdis_r1", ReadData1, 32'hF8F8F8F8);

        // Same index on both ports, then in-cycle read change
        ReadReg1 = 2'd3; ReadReg2 = 2'd3; #1;
        check_ports("dual_same");
        ReadReg1 = 2'd0; #1;
        check("read_change", ReadData1, 32'hF0F0F0F0);

        // Bypass / same-edge write-read
        ReadReg1 = 2'd2;
        @(negedge Clock);
        RegWrite = 1'b1; WriteRegNo = 2'd2; WriteData = 32'hDEADBEEF; #1;
`ifdef REG_FILE_BYPASS_EN
        check("byp_before", ReadData1, 32'hDEADBEEF);
`else
        check("byp_before", ReadData1, 32'hFAFAFAFA);
`endif
        @(posedge Clock); model[2] = 32'hDEADBEEF; #1;
        check("byp_after", ReadData1, 32'hDEADBEEF);

        // Asynchronous reset between edges
        @(negedge Clock);
        RegWrite = 1'b0; #2;
        Reset = 1'b0; clear_model(); #1;
        for (int i = 0; i < 4; i++) begin
            ReadReg1 = 2'(i); ReadReg2 = 2'(i ^ 1); #1;
            check_ports("async_rst");
        end

        // Reset release coincident with a write edge: target may or may not capture
        @(negedge Clock);
        RegWrite = 1'b1; WriteRegNo = 2'd1; WriteData = 32'hA5A5A5A5;
        ReadReg1 = 2'd1; ReadReg2 = 2'd0;
        @(posedge Clock);
        Reset = 1'b1;
        #1;
        tests++;
        assert (ReadData1 === 32'h0 || ReadData1 === 32'hA5A5A5A5) else begin
            fails++;
            $error("FAIL rel_target observed=%h expected=00000000|a5a5a5a5", ReadData1);
        end
        for (int i = 0; i < 4; i++) begin
            if (i != 1) begin
                ReadReg2 = 2'(i); #1;
                check("rel_other", ReadData2, exp_read(ReadReg2));
            end
        end
        do_write(1'b1, 2'd1, 32'h0BADF00D);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            @(negedge Clock);
            RegWrite   = 1'($urandom_range(0, 1));
            WriteRegNo = 2'($urandom_range(0, 3));
            WriteData  = $urandom;
            ReadReg1   = 2'($urandom_range(0, 3));
            ReadReg2   = 2'($urandom_range(0, 3));
            #1;
            check_ports("rnd_pre");
            ReadReg1 = 2'($urandom_range(0, 3)); #1;
            check_ports("rnd_rdchg");
            if ($urandom_range(0, 15) == 0) begin
                #1; Reset = 1'b0; clear_model(); #1;
                check_ports("rnd_rst");
                #1; Reset = 1'b1;
            end
            @(posedge Clock);
            if (RegWrite && Reset) model[WriteRegNo] = WriteData;
            #1;
            check_ports("rnd_post");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
